// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send, then shifts
// a command byte out on device-generated clock falls and checks the device ACK.

module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic line_f
);
    localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

    logic [1:0]       sync;
    logic [FLT_W-1:0] cnt;

    // Filtered level only follows the synchronised line after FILTER_LEN differing samples in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= 2'b11;
            cnt    <= '0;
            line_f <= 1'b1;
        end else begin
            sync <= {sync[0], line_i};
            if (sync[1] == line_f) begin
                cnt <= '0;
            end else if (cnt == FLT_W'(FILTER_LEN - 1)) begin
                line_f <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module ps2_host_tx #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int INHIBIT_US  = 120,
    parameter int TIMEOUT_US  = 15000,
    parameter int FILTER_LEN  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int CYC_PER_US = CLK_FREQ_HZ / 1_000_000;
    localparam int INH_CYC    = CYC_PER_US * INHIBIT_US;
    localparam int TO_CYC     = CYC_PER_US * TIMEOUT_US;
    localparam int INH_W      = $clog2(INH_CYC + 1);
    localparam int TO_W       = $clog2(TO_CYC + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_RTS     = 3'd2;
    localparam logic [2:0] S_SHIFT   = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;

    logic             clk_f, data_f, clk_f_q, fall;
    logic [2:0]       state;
    logic [9:0]       shift;
    logic [3:0]       bit_cnt;
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  wd_cnt;
    logic             wd_active, wd_expire, accept;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_flt (
        .clk(clk), .rst(rst), .line_i(ps2_clk_i), .line_f(clk_f)
    );
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_flt (
        .clk(clk), .rst(rst), .line_i(ps2_data_i), .line_f(data_f)
    );

    assign fall      = clk_f_q & ~clk_f;
    // The done/err pulse cycle is already IDLE but must not accept yet.
    assign tx_ready  = (state == S_IDLE) && !tx_done && !tx_err;
    assign busy      = ~tx_ready;
    assign accept    = tx_valid && tx_ready;
    assign wd_active = (state == S_SHIFT) || (state == S_ACK) || (state == S_WAIT);
    assign wd_expire = wd_active && !fall && (wd_cnt == TO_W'(TO_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            clk_f_q     <= 1'b1;
            shift       <= '0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
            wd_cnt      <= '0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            err_code    <= 2'b00;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            clk_f_q <= clk_f;
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            if (wd_active) wd_cnt <= fall ? '0 : wd_cnt + 1'b1;

            if (wd_expire) begin
                state       <= S_IDLE;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                tx_err      <= 1'b1;
                err_code    <= 2'b10;
            end else begin
                case (state)
                    S_IDLE: if (accept) begin
                        shift      <= {1'b1, ~^tx_data, tx_data};
                        err_code   <= 2'b00;
                        inh_cnt    <= '0;
                        ps2_clk_oe <= 1'b1;
                        state      <= S_INHIBIT;
                    end
                    S_INHIBIT: if (inh_cnt == INH_W'(INH_CYC - 1)) begin
                        ps2_data_oe <= 1'b1;
                        state       <= S_RTS;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                    S_RTS: begin
                        ps2_clk_oe <= 1'b0;
                        bit_cnt    <= '0;
                        wd_cnt     <= '0;
                        state      <= S_SHIFT;
                    end
                    // Falls 1..8 present data LSB first, 9 parity, 10 releases for the stop bit.
                    S_SHIFT: if (fall) begin
                        ps2_data_oe <= ~shift[bit_cnt];
                        bit_cnt     <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd9) state <= S_ACK;
                    end
                    S_ACK: if (fall) begin
                        if (data_f) begin
                            tx_err   <= 1'b1;
                            err_code <= 2'b01;
                            state    <= S_IDLE;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: if (clk_f && data_f) begin
                        tx_done <= 1'b1;
                        state   <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
